// File: rtl/scene_pkg.sv
// Shared types and helpers for the render-domain scene sequencer.
package scene_pkg;

  localparam int ANGLE_BITS_DEF = 8;
  localparam int IDX_BITS_DEF   = 10;

  // Widest flat parameter vector and widest single field the helper handles.
  localparam int FLAT_MAX  = 512;
  localparam int FIELD_MAX = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_NEXT
  } scene_state_t;

  function automatic logic [FIELD_MAX-1:0] slot_field(
    input logic [FLAT_MAX-1:0] flat,
    input int                  idx,
    input int                  width
  );
    logic [FLAT_MAX-1:0]  sh;
    logic [FIELD_MAX-1:0] mask;
    sh   = flat >> (idx * width);
    mask = (FIELD_MAX'(1) << width) - FIELD_MAX'(1);
    return sh[FIELD_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/angle_bank.sv
// Per-object and camera rotation angles, stepped on every frame pulse.
// Within a slot, axis a occupies [a*ANGLE_BITS +: ANGLE_BITS] (x lowest, z highest).
module angle_bank
  import scene_pkg::*;
#(
  parameter int                     N_OBJECTS  = 4,
  parameter int                     ANGLE_BITS = ANGLE_BITS_DEF,
  parameter logic [N_OBJECTS*4-1:0] OBJ_SPEED  = {N_OBJECTS{4'd1}}
) (
  input  logic                              clk_render,
  input  logic                              rst_render,
  input  logic                              step,
  input  logic [2:0]                        axis_en,
  input  logic                              cam_en,
  output logic [N_OBJECTS*3*ANGLE_BITS-1:0] obj_ang,
  output logic [3*ANGLE_BITS-1:0]           cam_ang
);

  logic [ANGLE_BITS-1:0] obj_r [N_OBJECTS][3];
  logic [ANGLE_BITS-1:0] cam_r [3];
  logic [ANGLE_BITS-1:0] speed [N_OBJECTS];

  for (genvar i = 0; i < N_OBJECTS; i++) begin : g_slot
    localparam logic [FIELD_MAX-1:0] SPEED_I = slot_field(FLAT_MAX'(OBJ_SPEED), i, 4);
    assign speed[i] = ANGLE_BITS'(SPEED_I);
    for (genvar a = 0; a < 3; a++) begin : g_axis
      assign obj_ang[(i*3+a)*ANGLE_BITS +: ANGLE_BITS] = obj_r[i][a];
    end
  end

  for (genvar a = 0; a < 3; a++) begin : g_cam
    assign cam_ang[a*ANGLE_BITS +: ANGLE_BITS] = cam_r[a];
  end

  // Camera mode steps only the camera; object angles freeze and vice versa.
  always_ff @(posedge clk_render or posedge rst_render) begin
    if (rst_render) begin
      for (int i = 0; i < N_OBJECTS; i++) begin
        for (int a = 0; a < 3; a++) begin
          obj_r[i][a] <= '0;
        end
      end
      for (int a = 0; a < 3; a++) begin
        cam_r[a] <= '0;
      end
    end else if (step) begin
      for (int a = 0; a < 3; a++) begin
        if (axis_en[a]) begin
          if (cam_en) begin
            cam_r[a] <= cam_r[a] + ANGLE_BITS'(1);
          end else begin
            for (int i = 0; i < N_OBJECTS; i++) begin
              obj_r[i][a] <= obj_r[i][a] + speed[i];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/scene_sequencer.sv
// Frame scheduler: swaps the framebuffer, flags the camera packet, then walks
// each object's triangle range through the feeder one slot at a time.
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int                            N_OBJECTS    = 4,
  parameter int                            ANGLE_BITS   = ANGLE_BITS_DEF,
  parameter int                            IDX_BITS     = IDX_BITS_DEF,
  parameter logic [N_OBJECTS*IDX_BITS-1:0] OBJ_BASE     = '0,
  parameter logic [N_OBJECTS*IDX_BITS-1:0] OBJ_COUNT    = '0,
  parameter logic [N_OBJECTS*4-1:0]        OBJ_SPEED    = {N_OBJECTS{4'd1}},
  parameter int                            WAIT_TIMEOUT = 1023,
  localparam int                           OBJ_W        = (N_OBJECTS > 1) ? $clog2(N_OBJECTS) : 1
) (
  input  logic                              clk_render,
  input  logic                              rst_render,
  input  logic                              frame_start,
  input  logic                              renderer_busy,
  input  logic [2:0]                        sw_axis_en,
  input  logic                              sw_cam_en,
  input  logic                              tri_valid,
  input  logic                              tri_ready,
  input  logic                              feeder_busy,
  output logic                              begin_frame,
  output logic                              feeder_start,
  output logic [IDX_BITS-1:0]               feeder_base,
  output logic [IDX_BITS-1:0]               feeder_count,
  output logic [OBJ_W-1:0]                  obj_idx,
  output logic                              cam_valid,
  output logic                              model_valid,
  output logic [N_OBJECTS*3*ANGLE_BITS-1:0] obj_ang,
  output logic [3*ANGLE_BITS-1:0]           cam_ang,
  output logic                              seq_busy,
  output logic [7:0]                        frame_skips,
  output logic [7:0]                        timeouts
);

  localparam int               TMO_W    = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [OBJ_W-1:0] LAST_IDX = OBJ_W'(N_OBJECTS - 1);

  scene_state_t        state;
  logic                cam_flag;
  logic [TMO_W-1:0]    wait_cnt;
  logic                accept;
  logic [OBJ_W-1:0]    next_idx;
  logic [IDX_BITS-1:0] base_tbl  [N_OBJECTS];
  logic [IDX_BITS-1:0] count_tbl [N_OBJECTS];

  for (genvar i = 0; i < N_OBJECTS; i++) begin : g_tbl
    localparam logic [FIELD_MAX-1:0] BASE_I  = slot_field(FLAT_MAX'(OBJ_BASE), i, IDX_BITS);
    localparam logic [FIELD_MAX-1:0] COUNT_I = slot_field(FLAT_MAX'(OBJ_COUNT), i, IDX_BITS);
    assign base_tbl[i]  = BASE_I[IDX_BITS-1:0];
    assign count_tbl[i] = COUNT_I[IDX_BITS-1:0];
  end

  assign accept      = frame_start && (state == ST_IDLE) && !renderer_busy;
  assign next_idx    = obj_idx + OBJ_W'(1);
  assign cam_valid   = tri_valid && cam_flag;
  assign model_valid = tri_valid && !cam_flag;
  assign seq_busy    = (state != ST_IDLE);

  // Slot base/count are loaded on entry to START so they are already valid
  // during START and stay put until the slot is retired in NEXT.
  always_ff @(posedge clk_render or posedge rst_render) begin
    if (rst_render) begin
      state        <= ST_IDLE;
      begin_frame  <= 1'b0;
      feeder_start <= 1'b0;
      feeder_base  <= '0;
      feeder_count <= '0;
      obj_idx      <= '0;
      cam_flag     <= 1'b1;
      wait_cnt     <= '0;
      frame_skips  <= '0;
      timeouts     <= '0;
    end else begin
      begin_frame  <= 1'b0;
      feeder_start <= 1'b0;

      if (frame_start && !accept && (frame_skips != 8'hFF)) begin
        frame_skips <= frame_skips + 8'd1;
      end

      // Acceptance beats a same-cycle handshake so the new frame keeps its camera packet.
      if (accept) begin
        cam_flag <= 1'b1;
      end else if (tri_valid && tri_ready) begin
        cam_flag <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            begin_frame  <= 1'b1;
            obj_idx      <= '0;
            feeder_base  <= base_tbl[0];
            feeder_count <= count_tbl[0];
            state        <= ST_START;
          end
        end
        ST_START: begin
          if (feeder_count == '0) begin
            state <= ST_NEXT;
          end else begin
            feeder_start <= 1'b1;
            wait_cnt     <= TMO_W'(WAIT_TIMEOUT - 1);
            state        <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (feeder_busy) begin
            state <= ST_WAIT_DONE;
          end else if (wait_cnt == '0) begin
            if (timeouts != 8'hFF) begin
              timeouts <= timeouts + 8'd1;
            end
            state <= ST_NEXT;
          end else begin
            wait_cnt <= wait_cnt - TMO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!feeder_busy) begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (obj_idx == LAST_IDX) begin
            state <= ST_IDLE;
          end else begin
            obj_idx      <= next_idx;
            feeder_base  <= base_tbl[next_idx];
            feeder_count <= count_tbl[next_idx];
            state        <= ST_START;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  angle_bank #(
    .N_OBJECTS (N_OBJECTS),
    .ANGLE_BITS(ANGLE_BITS),
    .OBJ_SPEED (OBJ_SPEED)
  ) u_angle_bank (
    .clk_render(clk_render),
    .rst_render(rst_render),
    .step      (frame_start),
    .axis_en   (sw_axis_en),
    .cam_en    (sw_cam_en),
    .obj_ang   (obj_ang),
    .cam_ang   (cam_ang)
  );

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed bench for scene_sequencer: a main two-object instance, an instance
// with an empty first slot, and an all-empty scene driven from a vector table.
module tb_scene_sequencer;

  logic clk_render = 1'b0;
  logic rst_render;
  always #5 clk_render = ~clk_render;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_render);
    #1;
  endtask

  // ---------------- instance A: base {0,100}, count {100,12}, speed {3,1}
  logic        fs_a, rb_a, cam_en_a, tv_a, tr_a, fbusy_a;
  logic [2:0]  axis_a;
  logic        bf_a, fst_a, cv_a, mv_a, busy_a;
  logic [9:0]  fbase_a, fcnt_a;
  logic [0:0]  idx_a;
  logic [47:0] oang_a;
  logic [23:0] cang_a;
  logic [7:0]  skips_a, tmo_a;

  scene_sequencer #(
    .N_OBJECTS(2), .ANGLE_BITS(8), .IDX_BITS(10),
    .OBJ_BASE({10'd100, 10'd0}), .OBJ_COUNT({10'd12, 10'd100}),
    .OBJ_SPEED({4'd1, 4'd3}), .WAIT_TIMEOUT(8)
  ) dut_a (
    .clk_render(clk_render), .rst_render(rst_render),
    .frame_start(fs_a), .renderer_busy(rb_a),
    .sw_axis_en(axis_a), .sw_cam_en(cam_en_a),
    .tri_valid(tv_a), .tri_ready(tr_a), .feeder_busy(fbusy_a),
    .begin_frame(bf_a), .feeder_start(fst_a),
    .feeder_base(fbase_a), .feeder_count(fcnt_a), .obj_idx(idx_a),
    .cam_valid(cv_a), .model_valid(mv_a),
    .obj_ang(oang_a), .cam_ang(cang_a),
    .seq_busy(busy_a), .frame_skips(skips_a), .timeouts(tmo_a)
  );

  // Feeder model: busy for count+2 cycles after each kick, when enabled.
  logic fm_en;
  int   fm_cnt;
  always @(posedge clk_render or posedge rst_render) begin
    if (rst_render) fm_cnt <= 0;
    else if (fst_a && fm_en) fm_cnt <= int'(fcnt_a) + 2;
    else if (fm_cnt > 0) fm_cnt <= fm_cnt - 1;
  end
  assign fbusy_a = (fm_cnt > 0);

  // ---------------- instance B: count {0,5}, base {0,200}
  logic        fs_b;
  logic        bf_b, fst_b, cv_b, mv_b, busy_b;
  logic [9:0]  fbase_b, fcnt_b;
  logic [0:0]  idx_b;
  logic [47:0] oang_b;
  logic [23:0] cang_b;
  logic [7:0]  skips_b, tmo_b;

  scene_sequencer #(
    .N_OBJECTS(2), .ANGLE_BITS(8), .IDX_BITS(10),
    .OBJ_BASE({10'd200, 10'd0}), .OBJ_COUNT({10'd5, 10'd0}),
    .OBJ_SPEED({4'd1, 4'd1}), .WAIT_TIMEOUT(8)
  ) dut_b (
    .clk_render(clk_render), .rst_render(rst_render),
    .frame_start(fs_b), .renderer_busy(1'b0),
    .sw_axis_en(3'b000), .sw_cam_en(1'b0),
    .tri_valid(1'b0), .tri_ready(1'b0), .feeder_busy(1'b0),
    .begin_frame(bf_b), .feeder_start(fst_b),
    .feeder_base(fbase_b), .feeder_count(fcnt_b), .obj_idx(idx_b),
    .cam_valid(cv_b), .model_valid(mv_b),
    .obj_ang(oang_b), .cam_ang(cang_b),
    .seq_busy(busy_b), .frame_skips(skips_b), .timeouts(tmo_b)
  );

  // ---------------- instance C: all slots empty
  logic        fs_c, rb_c, tv_c, tr_c;
  logic        bf_c, fst_c, cv_c, mv_c, busy_c;
  logic [9:0]  fbase_c, fcnt_c;
  logic [0:0]  idx_c;
  logic [47:0] oang_c;
  logic [23:0] cang_c;
  logic [7:0]  skips_c, tmo_c;

  scene_sequencer #(
    .N_OBJECTS(2), .ANGLE_BITS(8), .IDX_BITS(10), .WAIT_TIMEOUT(8)
  ) dut_c (
    .clk_render(clk_render), .rst_render(rst_render),
    .frame_start(fs_c), .renderer_busy(rb_c),
    .sw_axis_en(3'b000), .sw_cam_en(1'b0),
    .tri_valid(tv_c), .tri_ready(tr_c), .feeder_busy(1'b0),
    .begin_frame(bf_c), .feeder_start(fst_c),
    .feeder_base(fbase_c), .feeder_count(fcnt_c), .obj_idx(idx_c),
    .cam_valid(cv_c), .model_valid(mv_c),
    .obj_ang(oang_c), .cam_ang(cang_c),
    .seq_busy(busy_c), .frame_skips(skips_c), .timeouts(tmo_c)
  );

  typedef struct packed {
    logic       fs, rb, tv, tr;
    logic       cv, mv, busy;
    logic       bf;
    logic [7:0] skips;
  } vec_t;

  vec_t vec [10];

  int elapsed;
  int kicks;
  logic any_bf;

  initial begin
    //           fs    rb    tv    tr    cv    mv    busy  bf    skips (after edge)
    vec[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vec[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vec[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vec[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vec[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
    vec[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
    vec[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    vec[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    vec[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2};
    vec[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2};

    rst_render = 1'b1;
    fs_a = 0; rb_a = 0; axis_a = 3'b000; cam_en_a = 0; tv_a = 1; tr_a = 0; fm_en = 1;
    fs_b = 0;
    fs_c = 0; rb_c = 0; tv_c = 0; tr_c = 0;
    tick; tick;

    // Reset values
    check("rst_begin_frame", 32'(bf_a), 32'd0);
    check("rst_feeder_start", 32'(fst_a), 32'd0);
    check("rst_feeder_base", 32'(fbase_a), 32'd0);
    check("rst_feeder_count", 32'(fcnt_a), 32'd0);
    check("rst_obj_idx", 32'(idx_a), 32'd0);
    check("rst_seq_busy", 32'(busy_a), 32'd0);
    check("rst_skips", 32'(skips_a), 32'd0);
    check("rst_timeouts", 32'(tmo_a), 32'd0);
    check("rst_obj_ang_lo", 32'(oang_a[31:0]), 32'd0);
    check("rst_cam_ang", 32'(cang_a), 32'd0);
    check("rst_cam_valid", 32'(cv_a), 32'd1);
    check("rst_model_valid", 32'(mv_a), 32'd0);
    tv_a = 0;
    rst_render = 1'b0;
    tick;

    // Vector table on the all-empty scene
    for (int i = 0; i < 10; i++) begin
      fs_c = vec[i].fs; rb_c = vec[i].rb; tv_c = vec[i].tv; tr_c = vec[i].tr;
      #1;
      check($sformatf("vec%0d_cam_valid", i), 32'(cv_c), 32'(vec[i].cv));
      check($sformatf("vec%0d_model_valid", i), 32'(mv_c), 32'(vec[i].mv));
      check($sformatf("vec%0d_seq_busy", i), 32'(busy_c), 32'(vec[i].busy));
      tick;
      check($sformatf("vec%0d_begin_frame", i), 32'(bf_c), 32'(vec[i].bf));
      check($sformatf("vec%0d_skips", i), 32'(skips_c), 32'(vec[i].skips));
    end
    fs_c = 0; tv_c = 0; tr_c = 0;
    check("empty_no_kick", 32'(fst_c), 32'd0);

    // Empty slot 0: kick for slot 1 at k+4
    fs_b = 1; tick; fs_b = 0;
    check("b_begin_frame", 32'(bf_b), 32'd1);
    elapsed = 1;
    while (!fst_b && elapsed < 20) begin
      tick; elapsed++;
    end
    check("b_kick_latency", 32'(elapsed), 32'd4);
    check("b_kick_base", 32'(fbase_b), 32'd200);
    check("b_kick_count", 32'(fcnt_b), 32'd5);
    check("b_kick_idx", 32'(idx_b), 32'd1);

    // Main frame on A
    axis_a = 3'b001;
    fs_a = 1; tick; fs_a = 0;
    check("a_begin_frame", 32'(bf_a), 32'd1);
    check("a_seq_busy", 32'(busy_a), 32'd1);
    check("a_slot0_x", 32'(oang_a[7:0]), 32'd3);
    check("a_slot0_y", 32'(oang_a[15:8]), 32'd0);
    check("a_slot1_x", 32'(oang_a[31:24]), 32'd1);
    check("a_no_early_kick", 32'(fst_a), 32'd0);
    tick;
    check("a_kick1", 32'(fst_a), 32'd1);
    check("a_kick1_base", 32'(fbase_a), 32'd0);
    check("a_kick1_count", 32'(fcnt_a), 32'd100);
    check("a_kick1_idx", 32'(idx_a), 32'd0);
    tv_a = 1; tr_a = 1; #1;
    check("a_first_tri_cam", 32'(cv_a), 32'd1);
    check("a_first_tri_model", 32'(mv_a), 32'd0);
    tick;
    check("a_second_tri_cam", 32'(cv_a), 32'd0);
    check("a_second_tri_model", 32'(mv_a), 32'd1);
    fs_a = 1; tick; fs_a = 0;
    check("a_busy_reject_bf", 32'(bf_a), 32'd0);
    check("a_busy_reject_skips", 32'(skips_a), 32'd1);
    check("a_busy_reject_slot0_x", 32'(oang_a[7:0]), 32'd6);
    check("a_busy_reject_slot1_x", 32'(oang_a[31:24]), 32'd2);
    check("a_third_tri_model", 32'(mv_a), 32'd1);
    tv_a = 0; tr_a = 0;
    elapsed = 2;
    while (!fst_a && elapsed < 400) begin
      tick; elapsed++;
    end
    check("a_kick2_interval", 32'(elapsed), 32'd106);
    check("a_kick2_base", 32'(fbase_a), 32'd100);
    check("a_kick2_count", 32'(fcnt_a), 32'd12);
    check("a_kick2_idx", 32'(idx_a), 32'd1);
    elapsed = 0;
    while (busy_a && elapsed < 100) begin
      tick; elapsed++;
    end
    check("a_idle_after_kick2", 32'(elapsed), 32'd17);
    check("a_timeouts_none", 32'(tmo_a), 32'd0);

    // Feeder never goes busy: each slot times out after 8 cycles
    fm_en = 0; axis_a = 3'b000;
    fs_a = 1; tick; fs_a = 0;
    tick;
    check("t_kick1", 32'(fst_a), 32'd1);
    elapsed = 0;
    do begin
      tick; elapsed++;
    end while (!fst_a && elapsed < 50);
    check("t_kick2_interval", 32'(elapsed), 32'd10);
    check("t_timeouts_1", 32'(tmo_a), 32'd1);
    elapsed = 0;
    while (busy_a && elapsed < 50) begin
      tick; elapsed++;
    end
    check("t_idle_after", 32'(elapsed), 32'd9);
    check("t_timeouts_2", 32'(tmo_a), 32'd2);
    fm_en = 1;

    // Saturating skip counter
    rb_a = 1; any_bf = 0;
    for (int i = 0; i < 300; i++) begin
      fs_a = 1; tick;
      if (bf_a) any_bf = 1;
    end
    fs_a = 0; rb_a = 0;
    check("sat_skips", 32'(skips_a), 32'd255);
    check("sat_no_begin_frame", 32'(any_bf), 32'd0);

    // Angle wrap: speed 3 for 86 frames from 0 -> 258 mod 256 = 2
    rst_render = 1; tick; rst_render = 0; tick;
    axis_a = 3'b001; rb_a = 1;
    for (int i = 0; i < 86; i++) begin
      fs_a = 1; tick; fs_a = 0; tick;
    end
    check("wrap_slot0_x", 32'(oang_a[7:0]), 32'd2);
    check("wrap_slot1_x", 32'(oang_a[31:24]), 32'd86);
    check("wrap_slot0_y", 32'(oang_a[15:8]), 32'd0);
    check("wrap_cam_still", 32'(cang_a), 32'd0);
    check("wrap_skips", 32'(skips_a), 32'd86);
    cam_en_a = 1; axis_a = 3'b110;
    fs_a = 1; tick; fs_a = 0;
    check("cam_step", 32'(cang_a), 32'h010100);
    check("cam_obj_frozen", 32'(oang_a[7:0]), 32'd2);
    cam_en_a = 0; axis_a = 3'b000; rb_a = 0;

    // Reset while waiting for slot 1 to finish
    fs_a = 1; tick; fs_a = 0;
    elapsed = 0;
    while (!(fst_a && idx_a == 1'b1) && elapsed < 300) begin
      tick; elapsed++;
    end
    check("r_reached_slot1", 32'(idx_a), 32'd1);
    tick; tick; tick;
    check("r_busy_before", 32'(busy_a), 32'd1);
    #2 rst_render = 1;
    #1;
    check("r_seq_busy", 32'(busy_a), 32'd0);
    check("r_obj_idx", 32'(idx_a), 32'd0);
    check("r_feeder_base", 32'(fbase_a), 32'd0);
    check("r_feeder_count", 32'(fcnt_a), 32'd0);
    check("r_skips", 32'(skips_a), 32'd0);
    check("r_obj_ang", 32'(oang_a[31:0]), 32'd0);
    check("r_cam_ang", 32'(cang_a), 32'd0);
    tick;
    rst_render = 0;
    kicks = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (fst_a) kicks++;
    end
    check("r_no_kick_after_reset", 32'(kicks), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scene_sequencer.md
# scene_sequencer

Render-domain frame scheduler that replaces the fixed camera-first, single-mesh kick logic at the top level. On each accepted frame start it swaps the framebuffer, marks the next triangle as the camera packet, and then walks `N_OBJECTS` triangle ranges through the triangle feeder one after another. It also keeps per-object and camera rotation angles. It sits between the display frame pulse (already synchronised), the triangle feeder and the render manager's transform-setup bus.

## Interface
Parameters:
- `N_OBJECTS`, 4: number of object slots, 1..16.
- `ANGLE_BITS`, 8: angle index width; angles wrap modulo 2^ANGLE_BITS.
- `IDX_BITS`, 10: triangle index and count width.
- `OBJ_BASE`, all 0: flat vector `N_OBJECTS*IDX_BITS` wide; slot i sits at bits [i*IDX_BITS +: IDX_BITS]. Gives the first triangle of each object.
- `OBJ_COUNT`, all 0: flat vector, same layout. Gives the triangle count per object; a count of 0 means the slot is empty.
- `OBJ_SPEED`, all 1: flat vector `N_OBJECTS*4` wide. Gives the per-object angle step per frame.
- `WAIT_TIMEOUT`, 1023: maximum cycles to wait for `feeder_busy` to rise after a start.

Ports:
- `clk_render`, in, 1: render clock.
- `rst_render`, in, 1: reset, asynchronous, active-high.
- `frame_start`, in, 1: one-cycle frame pulse, render domain.
- `renderer_busy`, in, 1: render manager busy.
- `sw_axis_en`, in, 3: rotation enables for x, y, z; already synchronised.
- `sw_cam_en`, in, 1: when high, steps camera angles instead of object angles.
- `tri_valid`, in, 1: feeder output valid.
- `tri_ready`, in, 1: render manager ready.
- `feeder_busy`, in, 1: feeder busy.
- `begin_frame`, out, 1: one-cycle framebuffer swap pulse.
- `feeder_start`, out, 1: one-cycle feeder kick.
- `feeder_base`, out, `IDX_BITS`: first triangle for the current kick.
- `feeder_count`, out, `IDX_BITS`: triangle count for the current kick.
- `obj_idx`, out, `$clog2(N_OBJECTS)` (minimum 1 bit): current object; selects the model transform upstream.
- `cam_valid`, out, 1: equals `tri_valid && cam_flag`.
- `model_valid`, out, 1: equals `tri_valid && !cam_flag`.
- `obj_ang`, out, `N_OBJECTS*3*ANGLE_BITS`: per-object angles, packed x, y, z per slot.
- `cam_ang`, out, `3*ANGLE_BITS`: camera angles, packed x, y, z.
- `seq_busy`, out, 1: high whenever the state is not IDLE.
- `frame_skips`, out, 8: saturating count of rejected frame starts.
- `timeouts`, out, 8: saturating count of feeder start timeouts.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, NEXT.
- Frame start is accepted only when `frame_start` is high, the state is IDLE and `renderer_busy` is low. Acceptance registers `begin_frame`=1, `cam_flag`=1, `obj_idx`=0 and moves to START.
- A rejected `frame_start` increments `frame_skips`, saturating at 255. The current sequence is not disturbed.
- Angle step happens on every `frame_start`, accepted or not:
  - `sw_cam_en`=1: each enabled camera axis adds 1.
  - `sw_cam_en`=0: for every slot i, each enabled axis adds `OBJ_SPEED[i]`.
  - All angle arithmetic is unsigned and wraps.
- START:
  - If `OBJ_COUNT[obj_idx]`==0: go to NEXT with no kick.
  - Otherwise: pulse `feeder_start`, hold `feeder_base`/`feeder_count` for the slot, go to WAIT_BUSY.
- WAIT_BUSY: `feeder_busy`=1 goes to WAIT_DONE. After `WAIT_TIMEOUT` cycles without it, increment `timeouts` (saturating) and go to NEXT.
- WAIT_DONE: `feeder_busy`=0 goes to NEXT.
- NEXT: if `obj_idx`==N_OBJECTS-1, go to IDLE; otherwise increment `obj_idx` and go to START.
- `cam_flag` clears on the first `tri_valid && tri_ready` after acceptance and stays clear until the next accepted frame. An empty scene (all counts 0) leaves `cam_flag` set until the next frame.
- `feeder_base`, `feeder_count` and `obj_idx` are stable from the START cycle through NEXT.

## Timing
- Reset values:
  - State IDLE.
  - All pulses 0, `cam_flag`=1, `obj_idx`=0.
  - `feeder_base`/`feeder_count` = 0.
  - All angles 0, counters 0, `seq_busy`=0.
- An accepted `frame_start` in cycle k gives:
  - cycle k+1: `begin_frame`=1, updated angles, state START;
  - cycle k+2: `feeder_start`=1.
- Each subsequent object kick follows WAIT_DONE exit by 2 cycles (NEXT, then START).
- `cam_valid`/`model_valid` are combinational from `tri_valid`, with zero latency.
- `frame_start` and the handshake that clears `cam_flag` in the same cycle: acceptance wins, `cam_flag`=1.
- Reset asserted mid-sequence returns everything to reset values immediately; no `feeder_start` is issued after reset until a new frame is accepted.

## Structure
- `scene_pkg` holds:
  - the `scene_state_t` enum;
  - the `ANGLE_BITS` and `IDX_BITS` defaults;
  - the slot-extraction function (flat vector, index → field).
- Sub-module `angle_bank` holds the per-slot angle registers and step adders. The FSM, `cam_flag` and the counters stay in `scene_sequencer`.

## Test plan
- N_OBJECTS=2, base {0, 100}, count {100, 12}, feeder model asserts busy for count+2 cycles → `begin_frame` at k+1, `feeder_start` at k+2 with (0, 100), then (100, 12); `seq_busy` returns to 0.
- First handshake after acceptance → `cam_valid`=1 for exactly that triangle; every later triangle gives `model_valid`=1.
- `frame_start` while `seq_busy` or `renderer_busy` is high → `frame_skips` increments, no `begin_frame`, angles still step; 300 rejections → `frame_skips` holds at 255.
- Count {0, 5} → no kick for slot 0; the kick for slot 1 comes 2 cycles after acceptance+1. All counts 0 → return to IDLE with `cam_flag` still 1.
- Feeder never raises busy, `WAIT_TIMEOUT`=8 → `timeouts`=1 per slot and the sequence completes.
- `OBJ_SPEED`=3, x enabled, 86 frames from 0 → angle 2 (wrapped); `sw_cam_en`=1 → only camera angles move. Reset in WAIT_DONE → all outputs return to reset values in the same cycle.
